// File: rtl/alu_ex_mem_if.sv
// EX-stage bus: decoded operands/controls into the ALU and the EX/MEM register outputs back out.
interface alu_ex_mem_if;
  logic        flush;
  logic [2:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        alu_src;
  logic [4:0]  rd_addr;
  logic [4:0]  ctrl_in;
  logic [4:0]  alu_ctrl;
  logic [31:0] alu_result_q;
  logic        branch_taken_q;
  logic [31:0] branch_target_q;
  logic [31:0] store_data_q;
  logic [4:0]  rd_addr_q;
  logic [4:0]  ctrl_q;
  logic        pc_redirect;

  modport slave (
    input  flush, alu_op, funct3, funct7, pc, rs1_data, rs2_data, imm, alu_src, rd_addr, ctrl_in,
    output alu_ctrl, alu_result_q, branch_taken_q, branch_target_q, store_data_q, rd_addr_q,
           ctrl_q, pc_redirect
  );

  modport master (
    output flush, alu_op, funct3, funct7, pc, rs1_data, rs2_data, imm, alu_src, rd_addr, ctrl_in,
    input  alu_ctrl, alu_result_q, branch_taken_q, branch_target_q, store_data_q, rd_addr_q,
           ctrl_q, pc_redirect
  );
endinterface

// File: rtl/alu_ex_mem.sv
// Execute stage: ALU control decode, 32-bit ALU/branch compare, target adder and the EX/MEM register.
module alu_ex_mem (
  input  logic         clk,
  input  logic         rst,
  alu_ex_mem_if.slave  bus
);
  localparam logic [4:0] C_ADD   = 5'd0;
  localparam logic [4:0] C_SUB   = 5'd1;
  localparam logic [4:0] C_SLL   = 5'd2;
  localparam logic [4:0] C_SLT   = 5'd3;
  localparam logic [4:0] C_SLTU  = 5'd4;
  localparam logic [4:0] C_XOR   = 5'd5;
  localparam logic [4:0] C_SRL   = 5'd6;
  localparam logic [4:0] C_SRA   = 5'd7;
  localparam logic [4:0] C_OR    = 5'd8;
  localparam logic [4:0] C_AND   = 5'd9;
  localparam logic [4:0] C_BEQ   = 5'd10;
  localparam logic [4:0] C_BNE   = 5'd11;
  localparam logic [4:0] C_BLT   = 5'd12;
  localparam logic [4:0] C_BGE   = 5'd13;
  localparam logic [4:0] C_BLTU  = 5'd14;
  localparam logic [4:0] C_BGEU  = 5'd15;
  localparam logic [4:0] C_PASSB = 5'd16;
  localparam logic [4:0] C_AUIPC = 5'd17;
  localparam logic [4:0] C_JAL   = 5'd18;
  localparam logic [4:0] C_JALR  = 5'd19;

  logic [4:0]  w_alu_ctrl;
  logic [31:0] w_a, w_b, w_result, w_target;
  logic [4:0]  w_shamt;
  logic        w_taken, w_alt;
  logic        w_unused_f7;

  logic [31:0] r_alu_result, r_branch_target, r_store_data;
  logic        r_branch_taken;
  logic [4:0]  r_rd_addr, r_ctrl;

  // Only funct7[5] distinguishes SUB/SRA; the other bits are don't-care here.
  assign w_unused_f7 = &{1'b0, bus.funct7[6], bus.funct7[4:0]};
  assign w_alt       = bus.funct7[5];

  always_comb begin
    w_alu_ctrl = C_ADD;
    case (bus.alu_op)
      3'b000: w_alu_ctrl = C_ADD;
      3'b001: begin
        case (bus.funct3)
          3'b000:  w_alu_ctrl = C_BEQ;
          3'b001:  w_alu_ctrl = C_BNE;
          3'b100:  w_alu_ctrl = C_BLT;
          3'b101:  w_alu_ctrl = C_BGE;
          3'b110:  w_alu_ctrl = C_BLTU;
          3'b111:  w_alu_ctrl = C_BGEU;
          default: w_alu_ctrl = C_ADD;
        endcase
      end
      3'b010, 3'b011: begin
        case (bus.funct3)
          // I-type has no SUBI, so funct7 only matters for R-type ADD/SUB
          3'b000:  w_alu_ctrl = (w_alt && !bus.alu_op[0]) ? C_SUB : C_ADD;
          3'b001:  w_alu_ctrl = C_SLL;
          3'b010:  w_alu_ctrl = C_SLT;
          3'b011:  w_alu_ctrl = C_SLTU;
          3'b100:  w_alu_ctrl = C_XOR;
          3'b101:  w_alu_ctrl = w_alt ? C_SRA : C_SRL;
          3'b110:  w_alu_ctrl = C_OR;
          default: w_alu_ctrl = C_AND;
        endcase
      end
      3'b100:  w_alu_ctrl = C_PASSB;
      3'b101:  w_alu_ctrl = C_AUIPC;
      3'b110:  w_alu_ctrl = C_JAL;
      default: w_alu_ctrl = C_JALR;
    endcase
  end

  assign bus.alu_ctrl = w_alu_ctrl;
  assign w_a     = bus.rs1_data;
  assign w_b     = bus.alu_src ? bus.imm : bus.rs2_data;
  assign w_shamt = w_b[4:0];

  always_comb begin
    w_result = '0;
    w_taken  = 1'b0;
    case (w_alu_ctrl)
      C_ADD:   w_result = w_a + w_b;
      C_SUB:   w_result = w_a - w_b;
      C_SLL:   w_result = w_a << w_shamt;
      C_SLT:   w_result = {31'b0, $signed(w_a) < $signed(w_b)};
      C_SLTU:  w_result = {31'b0, w_a < w_b};
      C_XOR:   w_result = w_a ^ w_b;
      C_SRL:   w_result = w_a >> w_shamt;
      C_SRA:   w_result = $signed(w_a) >>> w_shamt;
      C_OR:    w_result = w_a | w_b;
      C_AND:   w_result = w_a & w_b;
      C_BEQ:   w_taken  = (w_a == w_b);
      C_BNE:   w_taken  = (w_a != w_b);
      C_BLT:   w_taken  = ($signed(w_a) < $signed(w_b));
      C_BGE:   w_taken  = ($signed(w_a) >= $signed(w_b));
      C_BLTU:  w_taken  = (w_a < w_b);
      C_BGEU:  w_taken  = (w_a >= w_b);
      C_PASSB: w_result = w_b;
      C_AUIPC: w_result = bus.pc + w_b;
      C_JAL, C_JALR: begin
        w_result = bus.pc + 32'd4;
        w_taken  = 1'b1;
      end
      default: begin
        w_result = '0;
        w_taken  = 1'b0;
      end
    endcase
  end

  // JALR targets are register-relative and forced halfword-aligned; everything else is PC-relative.
  assign w_target = (w_alu_ctrl == C_JALR) ? ((bus.rs1_data + bus.imm) & ~32'd1)
                                           : (bus.pc + (bus.imm << 1));

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_alu_result    <= '0;
      r_branch_taken  <= 1'b0;
      r_branch_target <= '0;
      r_store_data    <= '0;
      r_rd_addr       <= '0;
      r_ctrl          <= '0;
    end else begin
      r_alu_result    <= w_result;
      r_branch_taken  <= w_taken;
      r_branch_target <= w_target;
      r_store_data    <= bus.rs2_data;
      r_rd_addr       <= bus.rd_addr;
      r_ctrl          <= bus.ctrl_in;
    end
  end

  assign bus.alu_result_q    = r_alu_result;
  assign bus.branch_taken_q  = r_branch_taken;
  assign bus.branch_target_q = r_branch_target;
  assign bus.store_data_q    = r_store_data;
  assign bus.rd_addr_q       = r_rd_addr;
  assign bus.ctrl_q          = r_ctrl;
  assign bus.pc_redirect     = r_ctrl[3] & r_branch_taken;
endmodule

// File: tb/tb_alu_ex_mem.sv
// Bench for alu_ex_mem: directed vector table, reset/flush sequences, random ops vs. a reference model.
module tb_alu_ex_mem;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_ex_mem_if bus ();
  alu_ex_mem dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] pc, a, rs2, imm;
    logic        src;
    logic [4:0]  rd, ctrl;
    logic        flush;
  } stim_t;

  typedef struct {
    logic [4:0]  code;
    logic [31:0] res;
    logic        tk;
    logic [31:0] tgt;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    bus.alu_op   = s.op;
    bus.funct3   = s.f3;
    bus.funct7   = s.f7;
    bus.pc       = s.pc;
    bus.rs1_data = s.a;
    bus.rs2_data = s.rs2;
    bus.imm      = s.imm;
    bus.alu_src  = s.src;
    bus.rd_addr  = s.rd;
    bus.ctrl_in  = s.ctrl;
    bus.flush    = s.flush;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag, input stim_t s, input exp_t e);
    logic [31:0] z;
    z = 32'd0;
    if (s.flush) begin
      chk({tag, " res"}, bus.alu_result_q, z);
      chk({tag, " tk"}, {31'b0, bus.branch_taken_q}, z);
      chk({tag, " tgt"}, bus.branch_target_q, z);
      chk({tag, " sd"}, bus.store_data_q, z);
      chk({tag, " rd"}, {27'b0, bus.rd_addr_q}, z);
      chk({tag, " ctrl"}, {27'b0, bus.ctrl_q}, z);
      chk({tag, " redir"}, {31'b0, bus.pc_redirect}, z);
    end else begin
      chk({tag, " res"}, bus.alu_result_q, e.res);
      chk({tag, " tk"}, {31'b0, bus.branch_taken_q}, {31'b0, e.tk});
      chk({tag, " tgt"}, bus.branch_target_q, e.tgt);
      chk({tag, " sd"}, bus.store_data_q, s.rs2);
      chk({tag, " rd"}, {27'b0, bus.rd_addr_q}, {27'b0, s.rd});
      chk({tag, " ctrl"}, {27'b0, bus.ctrl_q}, {27'b0, s.ctrl});
      chk({tag, " redir"}, {31'b0, bus.pc_redirect}, {31'b0, s.ctrl[3] & e.tk});
    end
  endtask

  // Reference model: table lookups for decode, plain arithmetic for execute.
  function automatic exp_t model(input stim_t s);
    exp_t e;
    int br_map [8] = '{10, 11, 0, 0, 12, 13, 14, 15};
    int rt_map [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    logic [31:0] b;
    int sh;
    e.res = 0; e.tk = 0;
    case (s.op)
      3'd0: e.code = 5'd0;
      3'd1: e.code = 5'(br_map[s.f3]);
      3'd2: e.code = 5'(rt_map[s.f3] + ((s.f7[5] && (s.f3 == 0 || s.f3 == 5)) ? 1 : 0));
      3'd3: e.code = 5'(rt_map[s.f3] + ((s.f7[5] && s.f3 == 5) ? 1 : 0));
      default: e.code = 5'(16 + int'(s.op) - 4);
    endcase
    b  = s.src ? s.imm : s.rs2;
    sh = int'(b % 32);
    case (e.code)
      0:  e.res = s.a + b;
      1:  e.res = s.a - b;
      2:  e.res = s.a * (32'd1 << sh);
      3:  e.res = ($signed(s.a) < $signed(b)) ? 1 : 0;
      4:  e.res = (s.a < b) ? 1 : 0;
      5:  e.res = s.a ^ b;
      6:  e.res = s.a / (32'd1 << sh);
      7:  e.res = s.a[31] ? ~((~s.a) >> sh) : (s.a >> sh);
      8:  e.res = s.a | b;
      9:  e.res = s.a & b;
      10: e.tk = (s.a == b);
      11: e.tk = (s.a != b);
      12: e.tk = ($signed(s.a) < $signed(b));
      13: e.tk = !($signed(s.a) < $signed(b));
      14: e.tk = (s.a < b);
      15: e.tk = !(s.a < b);
      16: e.res = b;
      17: e.res = s.pc + b;
      default: begin e.res = s.pc + 4; e.tk = 1; end
    endcase
    e.tgt = (e.code == 19) ? ((s.a + s.imm) & 32'hFFFF_FFFE) : (s.pc + s.imm * 2);
    return e;
  endfunction

  function automatic vec_t mk(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] pc, input logic [31:0] a, input logic [31:0] rs2,
                              input logic [31:0] imm, input logic src, input logic [4:0] ctrl,
                              input logic [4:0] code, input logic [31:0] res, input logic tk,
                              input logic [31:0] tgt);
    vec_t v;
    v.s = '{op: op, f3: f3, f7: f7, pc: pc, a: a, rs2: rs2, imm: imm, src: src,
            rd: 5'd7, ctrl: ctrl, flush: 1'b0};
    v.e = '{code: code, res: res, tk: tk, tgt: tgt};
    return v;
  endfunction

  initial begin
    vec_t  vt [$];
    stim_t s;
    exp_t  e;
    int    f7_opts [3] = '{0, 32, 127};

    // Hand-computed vectors: op f3 f7 pc a rs2 imm src ctrl | code res tk tgt
    vt.push_back(mk(3'b010, 3'b000, 7'h20, 32'h0, 32'd5, 32'd7, 32'h0, 1'b0, 5'b10000,
                    5'd1, 32'hFFFF_FFFE, 1'b0, 32'h0));
    vt.push_back(mk(3'b011, 3'b101, 7'h20, 32'h0, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 5'b10000,
                    5'd7, 32'hF800_0000, 1'b0, 32'h8));
    vt.push_back(mk(3'b001, 3'b100, 7'h00, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'd8, 1'b0, 5'b01000,
                    5'd12, 32'h0, 1'b1, 32'h110));
    vt.push_back(mk(3'b001, 3'b110, 7'h00, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'd8, 1'b0, 5'b01000,
                    5'd14, 32'h0, 1'b0, 32'h110));
    vt.push_back(mk(3'b110, 3'b000, 7'h00, 32'h200, 32'h0, 32'h0, 32'h10, 1'b1, 5'b11000,
                    5'd18, 32'h204, 1'b1, 32'h220));
    vt.push_back(mk(3'b111, 3'b000, 7'h00, 32'h40, 32'h1001, 32'h0, 32'h4, 1'b1, 5'b11000,
                    5'd19, 32'h44, 1'b1, 32'h1004));
    vt.push_back(mk(3'b011, 3'b000, 7'h20, 32'h0, 32'd10, 32'd0, 32'd3, 1'b1, 5'b10000,
                    5'd0, 32'd13, 1'b0, 32'd6));
    vt.push_back(mk(3'b010, 3'b001, 7'h00, 32'h0, 32'd1, 32'h25, 32'h0, 1'b0, 5'b10000,
                    5'd2, 32'h20, 1'b0, 32'h0));
    vt.push_back(mk(3'b010, 3'b010, 7'h00, 32'h0, 32'hFFFF_FFFF, 32'd0, 32'h0, 1'b0, 5'b10000,
                    5'd3, 32'd1, 1'b0, 32'h0));
    vt.push_back(mk(3'b010, 3'b011, 7'h00, 32'h0, 32'hFFFF_FFFF, 32'd0, 32'h0, 1'b0, 5'b10000,
                    5'd4, 32'd0, 1'b0, 32'h0));
    vt.push_back(mk(3'b001, 3'b010, 7'h00, 32'h0, 32'd3, 32'd4, 32'h0, 1'b0, 5'b01000,
                    5'd0, 32'd7, 1'b0, 32'h0));
    vt.push_back(mk(3'b101, 3'b000, 7'h00, 32'h1000, 32'h0, 32'h0, 32'h2000, 1'b1, 5'b10000,
                    5'd17, 32'h3000, 1'b0, 32'h5000));
    vt.push_back(mk(3'b100, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0, 32'hABCD, 1'b1, 5'b10000,
                    5'd16, 32'hABCD, 1'b0, 32'h1579A));
    vt.push_back(mk(3'b000, 3'b000, 7'h00, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'd2, 1'b1, 5'b10000,
                    5'd0, 32'd1, 1'b0, 32'd4));
    vt.push_back(mk(3'b001, 3'b111, 7'h00, 32'h8, 32'd5, 32'd5, 32'h0, 1'b0, 5'b01000,
                    5'd15, 32'h0, 1'b1, 32'h8));

    // Reset with live, nonzero inputs: registers clear, alu_ctrl still decodes.
    drive(vt[0].s);
    bus.ctrl_in = 5'b11111;
    rst = 1'b1;
    step();
    chk("rst alu_ctrl", {27'b0, bus.alu_ctrl}, 32'd1);
    chk_regs("rst", '{flush: 1'b1, default: '0}, vt[0].e);
    rst = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i].s);
      #1;
      chk($sformatf("vec%0d alu_ctrl", i), {27'b0, bus.alu_ctrl}, {27'b0, vt[i].e.code});
      step();
      chk_regs($sformatf("vec%0d", i), vt[i].s, vt[i].e);
    end

    // Taken branch lands and redirects, then the same branch flushed.
    s = vt[2].s;
    s.ctrl = 5'b11111;
    drive(s);
    step();
    chk("br redir", {31'b0, bus.pc_redirect}, 32'd1);
    s.flush = 1'b1;
    drive(s);
    step();
    chk("flush ctrl_q", {27'b0, bus.ctrl_q}, 32'd0);
    chk("flush tk", {31'b0, bus.branch_taken_q}, 32'd0);
    chk("flush redir", {31'b0, bus.pc_redirect}, 32'd0);
    chk("flush tgt", bus.branch_target_q, 32'd0);

    // Reset wins over flush and over a live taken jump.
    s.flush = 1'b0;
    drive(s);
    step();
    chk("pre-rst redir", {31'b0, bus.pc_redirect}, 32'd1);
    s.flush = 1'b1;
    drive(s);
    rst = 1'b1;
    step();
    chk("rst+flush ctrl_q", {27'b0, bus.ctrl_q}, 32'd0);
    chk("rst+flush redir", {31'b0, bus.pc_redirect}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 300; i++) begin
      s.op    = 3'($urandom_range(0, 7));
      s.f3    = 3'($urandom_range(0, 7));
      s.f7    = 7'(f7_opts[$urandom_range(0, 2)]);
      s.pc    = $urandom & 32'hFFFF_FFFC;
      s.a     = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom : $urandom;
      s.rs2   = ($urandom_range(0, 3) == 0) ? s.a : $urandom;
      s.imm   = $urandom;
      s.src   = 1'($urandom);
      s.rd    = 5'($urandom);
      s.ctrl  = 5'($urandom);
      s.flush = ($urandom_range(0, 9) == 0);
      e = model(s);
      drive(s);
      #1;
      chk($sformatf("rnd%0d alu_ctrl", i), {27'b0, bus.alu_ctrl}, {27'b0, e.code});
      step();
      chk_regs($sformatf("rnd%0d", i), s, e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
